// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary 3x3 convolution engine.
// The window helpers fix the pixel-to-weight-bit mapping in one place.
package bnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WLOAD,
        ST_HDR,
        ST_FILL,
        ST_CONV,
        ST_DONE
    } state_e;

    localparam int MIN_N = 3;
    localparam int POP_W = 4;
    localparam int WIN_W = 9;
    localparam logic [15:0] END_MARK_DEF = 16'h00FF;

    // Oldest row lands in weight bits [2:0], newest row in [8:6].
    function automatic logic [WIN_W-1:0] window_bits(input logic [2:0] row_old,
                                                     input logic [2:0] row_mid,
                                                     input logic [2:0] row_new);
        return {row_new, row_mid, row_old};
    endfunction

    function automatic logic [POP_W-1:0] popcount9(input logic [WIN_W-1:0] v);
        logic [POP_W-1:0] p;
        p = '0;
        for (int i = 0; i < WIN_W; i++) begin
            p = p + POP_W'(v[i]);
        end
        return p;
    endfunction

endpackage

// File: rtl/bnn_row_conv.sv
// One filter applied across a full output row: XNOR-popcount per column, thresholded.
// Columns past the image width are computed anyway; the caller masks them.
module bnn_row_conv
    import bnn_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] row_n2,
    input  logic [DATA_W-1:0] row_n1,
    input  logic [DATA_W-1:0] row_n,
    input  logic [WIN_W-1:0]  weight,
    input  logic [POP_W-1:0]  thresh,
    output logic [DATA_W-1:0] out_row
);

    logic [DATA_W+1:0] pad_n2;
    logic [DATA_W+1:0] pad_n1;
    logic [DATA_W+1:0] pad_n;
    logic [WIN_W-1:0]  win;
    logic [POP_W-1:0]  pop;

    // Two zero columns on the left keep every 3-wide slice in range.
    assign pad_n2 = {2'b00, row_n2};
    assign pad_n1 = {2'b00, row_n1};
    assign pad_n  = {2'b00, row_n};

    always_comb begin
        out_row = '0;
        win     = '0;
        pop     = '0;
        for (int j = 0; j < DATA_W; j++) begin
            win        = window_bits(pad_n2[j +: 3], pad_n1[j +: 3], pad_n[j +: 3]);
            pop        = popcount9(win ~^ weight);
            out_row[j] = (pop > thresh);
        end
    end

endmodule

// File: rtl/bnn_conv_engine.sv
// Streams binary images from input SRAM, runs NUM_FILT 3x3 XNOR-popcount filters
// per output row and writes one result word per filter to output SRAM.
module bnn_conv_engine
    import bnn_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 12,
    parameter int                NUM_FILT = 4,
    parameter logic [DATA_W-1:0] END_MARK = DATA_W'(END_MARK_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [3:0]        cfg_thresh,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data
);

    localparam int CNT_W = 4;
    localparam int N_W   = $clog2(DATA_W + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         fill_left_q, fill_left_d;
    logic [N_W-1:0]     rows_left_q, rows_left_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [POP_W-1:0]   thresh_q, thresh_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               rd_fresh_q, rd_fresh_d;
    logic [ADDR_W-1:0]  wm_addr_q, wm_addr_d;
    logic [ADDR_W-1:0]  out_cnt_q, out_cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [DATA_W-1:0]  row_n2_q, row_n2_d;
    logic [DATA_W-1:0]  row_n1_q, row_n1_d;
    logic [DATA_W-1:0]  row_n_q, row_n_d;
    logic [WIN_W-1:0]   wreg_q [NUM_FILT];
    logic [WIN_W-1:0]   wreg_d [NUM_FILT];

    logic [DATA_W-1:0]  filt_row [NUM_FILT];
    logic [DATA_W-1:0]  sel_row;
    logic [DATA_W-1:0]  col_mask;
    logic [DATA_W-1:0]  hdr;
    logic               hdr_bad;
    logic               unused_wbits;

    assign hdr          = sram_dut_read_data;
    assign hdr_bad      = (hdr < DATA_W'(MIN_N)) || (hdr > DATA_W'(DATA_W));
    assign unused_wbits = ^wmem_dut_read_data[DATA_W-1:WIN_W];

    for (genvar gf = 0; gf < NUM_FILT; gf++) begin : g_filt
        bnn_row_conv #(.DATA_W(DATA_W)) u_row_conv (
            .row_n2  (row_n2_q),
            .row_n1  (row_n1_q),
            .row_n   (row_n_q),
            .weight  (wreg_q[gf]),
            .thresh  (thresh_q),
            .out_row (filt_row[gf])
        );
    end

    always_comb begin
        sel_row = '0;
        for (int f = 0; f < NUM_FILT; f++) begin
            if (cnt_q == CNT_W'(f)) sel_row = filt_row[f];
        end
    end

    // Only columns 0..N-3 have a complete 3x3 window.
    always_comb begin
        col_mask = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (j < int'(n_q) - 2) col_mask[j] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_left_d = fill_left_q;
        rows_left_d = rows_left_q;
        n_d         = n_q;
        thresh_d    = thresh_q;
        busy_d      = busy_q;
        err_d       = err_q;
        rd_addr_d   = rd_addr_q;
        wm_addr_d   = wm_addr_q;
        out_cnt_d   = out_cnt_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        row_n2_d    = row_n2_q;
        row_n1_d    = row_n1_q;
        row_n_d     = row_n_q;
        wreg_d      = wreg_q;
        done_d      = 1'b0;
        wr_en_d     = 1'b0;
        rd_fresh_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    thresh_d   = cfg_thresh;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    rd_addr_d  = '0;
                    rd_fresh_d = 1'b1;
                    wm_addr_d  = '0;
                    out_cnt_d  = '0;
                    cnt_d      = '0;
                    state_d    = ST_WLOAD;
                end
            end
            // Weight data trails its address by one cycle, hence NUM_FILT+1 cycles.
            ST_WLOAD: begin
                wm_addr_d = wm_addr_q + ADDR_W'(1);
                for (int f = 0; f < NUM_FILT; f++) begin
                    if (cnt_q == CNT_W'(f + 1)) wreg_d[f] = wmem_dut_read_data[WIN_W-1:0];
                end
                if (cnt_q == CNT_W'(NUM_FILT)) begin
                    state_d = ST_HDR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HDR: begin
                if (!rd_fresh_q) begin
                    if (hdr == END_MARK) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (hdr_bad) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        n_d         = N_W'(hdr);
                        rows_left_d = N_W'(hdr);
                        fill_left_d = 2'd3;
                        rd_addr_d   = rd_addr_q + ADDR_W'(1);
                        rd_fresh_d  = 1'b1;
                        state_d     = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (!rd_fresh_q) begin
                    row_n2_d    = row_n1_q;
                    row_n1_d    = row_n_q;
                    row_n_d     = sram_dut_read_data;
                    rows_left_d = rows_left_q - N_W'(1);
                    if (fill_left_q == 2'd1) begin
                        cnt_d   = '0;
                        state_d = ST_CONV;
                    end else begin
                        fill_left_d = fill_left_q - 2'd1;
                        rd_addr_d   = rd_addr_q + ADDR_W'(1);
                        rd_fresh_d  = 1'b1;
                    end
                end
            end
            // The next word (row or header) is always rd_addr+1; fetching it on the
            // first write cycle hides the read latency behind the writes.
            ST_CONV: begin
                wr_en_d   = 1'b1;
                wr_addr_d = out_cnt_q;
                wr_data_d = sel_row & col_mask;
                out_cnt_d = out_cnt_q + ADDR_W'(1);
                if (cnt_q == '0) begin
                    rd_addr_d  = rd_addr_q + ADDR_W'(1);
                    rd_fresh_d = 1'b1;
                end
                if (cnt_q == CNT_W'(NUM_FILT - 1)) begin
                    if (rows_left_q != '0) begin
                        fill_left_d = 2'd1;
                        state_d     = ST_FILL;
                    end else begin
                        state_d = ST_HDR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fill_left_q <= '0;
            rows_left_q <= '0;
            n_q         <= '0;
            thresh_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_addr_q   <= '0;
            rd_fresh_q  <= 1'b0;
            wm_addr_q   <= '0;
            out_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            row_n2_q    <= '0;
            row_n1_q    <= '0;
            row_n_q     <= '0;
            for (int f = 0; f < NUM_FILT; f++) wreg_q[f] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_left_q <= fill_left_d;
            rows_left_q <= rows_left_d;
            n_q         <= n_d;
            thresh_q    <= thresh_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_addr_q   <= rd_addr_d;
            rd_fresh_q  <= rd_fresh_d;
            wm_addr_q   <= wm_addr_d;
            out_cnt_q   <= out_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            row_n2_q    <= row_n2_d;
            row_n1_q    <= row_n1_d;
            row_n_q     <= row_n_d;
            wreg_q      <= wreg_d;
        end
    end

    assign busy                   = busy_q;
    assign done                   = done_q;
    assign err                    = err_q;
    assign dut_sram_read_address  = rd_addr_q;
    assign dut_wmem_read_address  = wm_addr_q;
    assign dut_sram_write_address = wr_addr_q;
    assign dut_sram_write_data    = wr_data_q;
    assign wr_enable              = wr_en_q;

endmodule

// File: tb/tb_bnn_conv_engine.sv
// Directed bench for bnn_conv_engine: table of N=4 images plus hand sequences for
// end-of-job, bad headers, multi-image jobs and mid-job reset.
module tb_bnn_conv_engine;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 12;
    localparam int NUM_FILT = 4;
    localparam int EXP_W    = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [3:0]        cfg_thresh;
    logic              busy, done, err;
    logic [ADDR_W-1:0] rd_addr, wr_addr, wm_addr;
    logic [DATA_W-1:0] rd_data, wr_data, wm_data;
    logic              wr_enable;

    logic [DATA_W-1:0] imem [0:4095];
    logic [DATA_W-1:0] wmem [0:15];

    int                tests = 0;
    int                fails = 0;
    logic              mon_en;
    logic [ADDR_W-1:0] exp_ptr;
    logic [EXP_W-1:0]  exp_q[$];

    typedef struct packed {
        logic [3:0][DATA_W-1:0] rows;
        logic [3:0][DATA_W-1:0] w;
        logic [3:0]             th;
        logic [7:0][DATA_W-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    bnn_conv_engine #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_FILT (NUM_FILT)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .run                    (run),
        .cfg_thresh             (cfg_thresh),
        .busy                   (busy),
        .done                   (done),
        .err                    (err),
        .dut_sram_read_address  (rd_addr),
        .sram_dut_read_data     (rd_data),
        .dut_sram_write_address (wr_addr),
        .dut_sram_write_data    (wr_data),
        .wr_enable              (wr_enable),
        .dut_wmem_read_address  (wm_addr),
        .wmem_dut_read_data     (wm_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rd_data <= imem[rd_addr];
        wm_data <= wmem[wm_addr[3:0]];
    end

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && wr_enable === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", wr_addr, wr_data);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    fails++;
                    $display("FAIL write: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                             wr_addr, wr_data, e[EXP_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] d);
        exp_q.push_back({exp_ptr, d});
        exp_ptr = exp_ptr + ADDR_W'(1);
    endtask

    task automatic load_vec(input vec_t v);
        imem[0] = 16'd4;
        for (int i = 0; i < 4; i++) imem[1 + i] = v.rows[i];
        imem[5] = 16'h00FF;
        for (int f = 0; f < NUM_FILT; f++) wmem[f] = v.w[f];
        cfg_thresh = v.th;
        exp_ptr = '0;
        for (int k = 0; k < 8; k++) push_exp(v.exp[k]);
    endtask

    task automatic run_job(input logic exp_err, input string name);
        int cyc;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        cfg_thresh = ~cfg_thresh;
        check({name, "_busy_after_run"}, 32'(busy), 32'd1);
        check({name, "_err_cleared"}, 32'(err), 32'd0);
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_busy_fall"}, 32'(busy), 32'd0);
        check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        run = 1'b0;
        cfg_thresh = '0;
        mon_en = 1'b1;
        exp_ptr = '0;
        for (int i = 0; i < 4096; i++) imem[i] = '0;
        for (int i = 0; i < 16; i++) wmem[i] = '0;

        vecs[0].rows = {4{16'h000F}}; vecs[0].w = {4{16'h01FF}}; vecs[0].th = 4'd4; vecs[0].exp = {8{16'h0003}};
        vecs[1].rows = {4{16'h000F}}; vecs[1].w = {4{16'h0000}}; vecs[1].th = 4'd0; vecs[1].exp = {8{16'h0000}};
        vecs[2].rows = {4{16'h000F}}; vecs[2].w = {4{16'h01FF}}; vecs[2].th = 4'd8; vecs[2].exp = {8{16'h0003}};
        vecs[3].rows = {4{16'h000F}}; vecs[3].w = {4{16'h01FF}}; vecs[3].th = 4'd9; vecs[3].exp = {8{16'h0000}};
        vecs[4].rows = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
        vecs[4].w    = {16'hFE11, 16'h0022, 16'h0088, 16'h0111};
        vecs[4].th   = 4'd7;
        vecs[4].exp  = {16'h0002, 16'h0001, 16'h0000, 16'h0002, 16'h0001, 16'h0000, 16'h0002, 16'h0001};
        vecs[5].rows = {4{16'hFFFF}}; vecs[5].w = {4{16'h01FF}}; vecs[5].th = 4'd4; vecs[5].exp = {8{16'h0003}};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_en", 32'(wr_enable), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wm_addr", 32'(wm_addr), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            run_job(1'b0, $sformatf("vec%0d", v));
        end

        imem[0] = 16'h00FF;
        cfg_thresh = 4'd4;
        run_job(1'b0, "end_only");

        imem[0] = 16'd2;
        run_job(1'b1, "hdr_n2");
        imem[0] = 16'd17;
        run_job(1'b1, "hdr_n17");

        load_vec(vecs[0]);
        run_job(1'b0, "after_err");

        // Smallest legal image: one output row, only bit 0 live.
        imem[0] = 16'd3;
        for (int i = 1; i <= 3; i++) imem[i] = 16'h0007;
        imem[4] = 16'h00FF;
        cfg_thresh = 4'd4;
        exp_ptr = '0;
        for (int f = 0; f < NUM_FILT; f++) push_exp(16'h0001);
        run_job(1'b0, "n3");

        // N=5 then N=16; per-filter weights give popcounts 9,0,8,4 on all-ones windows.
        wmem[0] = 16'h01FF; wmem[1] = 16'h0000; wmem[2] = 16'h00FF; wmem[3] = 16'h000F;
        imem[0] = 16'd5;
        for (int i = 1; i <= 5; i++) imem[i] = 16'h001F;
        imem[6] = 16'd16;
        for (int i = 7; i <= 22; i++) imem[i] = 16'hFFFF;
        imem[23] = 16'h00FF;
        cfg_thresh = 4'd4;
        exp_ptr = '0;
        for (int r = 0; r < 3; r++) begin
            push_exp(16'h0007); push_exp(16'h0000); push_exp(16'h0007); push_exp(16'h0000);
        end
        for (int r = 0; r < 14; r++) begin
            push_exp(16'h3FFF); push_exp(16'h0000); push_exp(16'h3FFF); push_exp(16'h0000);
        end
        run_job(1'b0, "two_images");

        // Abort a job while it is writing, then rerun from scratch.
        load_vec(vecs[0]);
        exp_q.delete();
        mon_en = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        cyc = 0;
        while (wr_enable !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_write", 32'(wr_enable), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_wr_en", 32'(wr_enable), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rd_addr", 32'(rd_addr), 32'd0);
        check("abort_wr_addr", 32'(wr_addr), 32'd0);
        check("abort_wm_addr", 32'(wm_addr), 32'd0);
        reset = 1'b0;
        #1 mon_en = 1'b1;
        load_vec(vecs[0]);
        run_job(1'b0, "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
